// File: rtl/map_switch_ctrl.sv
// map_switch_ctrl: mapper-selection controller for map_mux generation 2.
// Synchronises a toggle req/ack handshake from the MCU. Switches the active mapper only
// after the CPU bus has been idle for a while, and keeps all mappers in reset across the change.
// The slot select, args, PRG mask and CHR base are registered outputs.
// Optional feature: define MAP_SWITCH_WDT_EN to bound the quiesce wait with a watchdog.
module map_switch_ctrl #(
  parameter int MAP_CNT     = 32,
  parameter int SEL_BITS    = 5,
  parameter int ARG_BITS    = 7,
  parameter int ADDR_BITS   = 23,
  parameter int IDLE_CYCLES = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int WDT_CYCLES  = 65535
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [23:0]          map_ctrl,
  input  logic                 map_ctrl_req,
  output logic                 map_ctrl_ack,
  input  logic                 m2,
  output logic [SEL_BITS-1:0]  select,
  output logic [ARG_BITS-1:0]  map_args,
  output logic [MAP_CNT-1:0]   map_reset,
  output logic [ADDR_BITS-1:0] prg_mask,
  output logic [ADDR_BITS-1:0] chr_base,
  output logic                 busy,
  output logic                 err
);

  localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int OFF_W  = 5;
  localparam logic [IDLE_W-1:0]    IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [OFF_W-1:0]     OFF_MAX   = OFF_W'(ADDR_BITS - 1);
  localparam logic [ADDR_BITS-1:0] ADDR_ONE  = ADDR_BITS'(1);
  localparam logic [MAP_CNT-1:0]   SLOT_ONE  = MAP_CNT'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_QUIESCE = 3'd1,
    ST_HOLD    = 3'd2,
    ST_APPLY   = 3'd3,
    ST_ACK     = 3'd4
  } state_t;

  // Reset vector with only the given slot released.
  function automatic logic [MAP_CNT-1:0] slot_reset(input logic [SEL_BITS-1:0] sel);
    return ~(SLOT_ONE << sel);
  endfunction

  // CHR offsets beyond the address space fold to the top bit.
  function automatic logic [OFF_W-1:0] clamp_off(input logic [OFF_W-1:0] off);
    if (off > OFF_MAX) begin
      return OFF_MAX;
    end else begin
      return off;
    end
  endfunction

  // CHR region starts at 1 << chr_off; PRG occupies everything below it.
  function automatic logic [ADDR_BITS-1:0] base_of(input logic [OFF_W-1:0] off);
    return ADDR_ONE << clamp_off(off);
  endfunction

  state_t                state_r;
  state_t                state_nxt;
  logic                  req_meta_r;
  logic                  req_sync_r;
  logic                  m2_meta_r;
  logic                  m2_sync_r;
  logic [SEL_BITS-1:0]   shadow_sel_r;
  logic [ARG_BITS-1:0]   shadow_args_r;
  logic                  pend_req_r;
  logic [IDLE_W-1:0]     idle_cnt_r;
  logic [HOLD_W-1:0]     hold_cnt_r;
  logic                  capture_s;
  logic                  reject_s;
  logic                  wdt_fire_s;
  logic                  wdt_expired_s;
  logic                  sel_valid_s;
  logic [SEL_BITS-1:0]   sel_in_s;
  logic [ARG_BITS-1:0]   args_in_s;
  logic                  ctrl_unused_s;

  assign sel_in_s      = map_ctrl[SEL_BITS-1:0];
  assign args_in_s     = map_ctrl[SEL_BITS+ARG_BITS-1:SEL_BITS];
  assign ctrl_unused_s = ^map_ctrl[23:SEL_BITS+ARG_BITS];
  assign sel_valid_s   = (32'(sel_in_s) < 32'(MAP_CNT));

`ifdef MAP_SWITCH_WDT_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);
  logic [WDT_W-1:0] wdt_cnt_r;

  assign wdt_expired_s = (wdt_cnt_r == WDT_LAST);

  // Watchdog: counts every cycle spent in QUIESCE, regardless of bus activity.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdt_cnt_r <= {WDT_W{1'b0}};
    end else if (state_r == ST_QUIESCE) begin
      wdt_cnt_r <= wdt_cnt_r + WDT_W'(1);
    end else begin
      wdt_cnt_r <= {WDT_W{1'b0}};
    end
  end
`else
  assign wdt_expired_s = 1'b0;
`endif

  // Two-flop synchronisers for the MCU request toggle and the CPU M2 strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_meta_r <= 1'b0;
      req_sync_r <= 1'b0;
      m2_meta_r  <= 1'b0;
      m2_sync_r  <= 1'b0;
    end else begin
      req_meta_r <= map_ctrl_req;
      req_sync_r <= req_meta_r;
      m2_meta_r  <= m2;
      m2_sync_r  <= m2_meta_r;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state logic and single-cycle control strobes.
  always_comb begin
    state_nxt  = state_r;
    capture_s  = 1'b0;
    reject_s   = 1'b0;
    wdt_fire_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_sync_r != map_ctrl_ack) begin
          capture_s = 1'b1;
          if (sel_valid_s) begin
            state_nxt = ST_QUIESCE;
          end else begin
            reject_s  = 1'b1;
            state_nxt = ST_ACK;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_QUIESCE: begin
        if (!m2_sync_r && (idle_cnt_r == IDLE_LAST)) begin
          state_nxt = ST_HOLD;
        end else if (wdt_expired_s) begin
          wdt_fire_s = 1'b1;
          state_nxt  = ST_HOLD;
        end else begin
          state_nxt = ST_QUIESCE;
        end
      end
      ST_HOLD: begin
        if (hold_cnt_r == HOLD_LAST) begin
          state_nxt = ST_APPLY;
        end else begin
          state_nxt = ST_HOLD;
        end
      end
      ST_APPLY: state_nxt = ST_ACK;
      ST_ACK:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Bus-idle counter: consecutive QUIESCE cycles with M2 low.
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt_r <= {IDLE_W{1'b0}};
    end else if ((state_r == ST_QUIESCE) && !m2_sync_r) begin
      idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
    end else begin
      idle_cnt_r <= {IDLE_W{1'b0}};
    end
  end

  // Hold counter: length of the all-mappers-in-reset window.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt_r <= {HOLD_W{1'b0}};
    end else if (state_r == ST_HOLD) begin
      hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
    end else begin
      hold_cnt_r <= {HOLD_W{1'b0}};
    end
  end

  // Shadow copy of the request, taken when IDLE accepts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_sel_r  <= {SEL_BITS{1'b0}};
      shadow_args_r <= {ARG_BITS{1'b0}};
      pend_req_r    <= 1'b0;
    end else if (capture_s) begin
      shadow_sel_r  <= sel_in_s;
      shadow_args_r <= args_in_s;
      pend_req_r    <= req_sync_r;
    end else begin
      shadow_sel_r  <= shadow_sel_r;
      shadow_args_r <= shadow_args_r;
      pend_req_r    <= pend_req_r;
    end
  end

  // Registered outputs: mapper configuration, reset vector, handshake and status.
  always_ff @(posedge clk) begin
    if (reset) begin
      select       <= {SEL_BITS{1'b0}};
      map_args     <= {ARG_BITS{1'b0}};
      map_reset    <= ~SLOT_ONE;
      prg_mask     <= {ADDR_BITS{1'b0}};
      chr_base     <= ADDR_ONE;
      map_ctrl_ack <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
    end else begin
      busy <= (state_nxt != ST_IDLE);
      if (state_r == ST_APPLY) begin
        // Release the new slot together with its configuration so the old slot never runs with it.
        select    <= shadow_sel_r;
        map_args  <= shadow_args_r;
        prg_mask  <= base_of(shadow_args_r[OFF_W-1:0]) - ADDR_ONE;
        chr_base  <= base_of(shadow_args_r[OFF_W-1:0]);
        map_reset <= slot_reset(shadow_sel_r);
        err       <= 1'b0;
      end else begin
        if (state_r == ST_HOLD) begin
          map_reset <= {MAP_CNT{1'b1}};
        end else begin
          map_reset <= map_reset;
        end
        if (reject_s || wdt_fire_s) begin
          err <= 1'b1;
        end else begin
          err <= err;
        end
      end
      if (state_r == ST_ACK) begin
        map_ctrl_ack <= pend_req_r;
      end else begin
        map_ctrl_ack <= map_ctrl_ack;
      end
    end
  end

endmodule

// File: tb/tb_map_switch_ctrl.sv
// Self-checking bench for map_switch_ctrl: one 32-slot instance and one 16-slot instance
// (the latter exercises out-of-range selects). Expected values come from a small model of
// the switch rules: latency formula, mask/base arithmetic and the current-mapper state.
`timescale 1ns/1ps
module tb_map_switch_ctrl;
  localparam int ADDR_BITS   = 23;
  localparam int IDLE_CYCLES = 4;
  localparam int HOLD_CYCLES = 16;
  localparam int WDT_CYCLES  = 100;
  localparam int SYNC_LAT    = 2;
  localparam int SWITCH_LAT  = 1 + IDLE_CYCLES + HOLD_CYCLES + 2;
  localparam int REQ_LAT     = SYNC_LAT + SWITCH_LAT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, m2;
  logic [23:0] map_ctrl, map_ctrl_b;
  logic        map_ctrl_req, map_ctrl_ack, req_b, ack_b;
  logic [4:0]  select, select_b;
  logic [6:0]  map_args, args_b;
  logic [31:0] map_reset;
  logic [15:0] map_reset_b;
  logic [22:0] prg_mask, chr_base, prg_mask_b, chr_base_b;
  logic        busy, err, busy_b, err_b;

  int checks = 0;
  int passed = 0;

  // Model state: the mapper the 32-slot DUT should currently have live.
  logic [4:0] cur_sel;
  logic [6:0] cur_args;

  map_switch_ctrl #(.MAP_CNT(32), .SEL_BITS(5), .ARG_BITS(7), .ADDR_BITS(ADDR_BITS),
                    .IDLE_CYCLES(IDLE_CYCLES), .HOLD_CYCLES(HOLD_CYCLES), .WDT_CYCLES(WDT_CYCLES)) dut (
    .clk(clk), .reset(reset), .map_ctrl(map_ctrl), .map_ctrl_req(map_ctrl_req),
    .map_ctrl_ack(map_ctrl_ack), .m2(m2), .select(select), .map_args(map_args),
    .map_reset(map_reset), .prg_mask(prg_mask), .chr_base(chr_base), .busy(busy), .err(err));

  map_switch_ctrl #(.MAP_CNT(16), .SEL_BITS(5), .ARG_BITS(7), .ADDR_BITS(ADDR_BITS),
                    .IDLE_CYCLES(IDLE_CYCLES), .HOLD_CYCLES(HOLD_CYCLES), .WDT_CYCLES(WDT_CYCLES)) dut16 (
    .clk(clk), .reset(reset), .map_ctrl(map_ctrl_b), .map_ctrl_req(req_b),
    .map_ctrl_ack(ack_b), .m2(m2), .select(select_b), .map_args(args_b),
    .map_reset(map_reset_b), .prg_mask(prg_mask_b), .chr_base(chr_base_b), .busy(busy_b), .err(err_b));

  function automatic logic [22:0] model_base(input logic [6:0] args);
    int off;
    off = int'(args) % 32;
    if (off > ADDR_BITS - 1) off = ADDR_BITS - 1;
    return 23'(64'd1 << off);
  endfunction

  function automatic logic [22:0] model_mask(input logic [6:0] args);
    return 23'(64'(model_base(args)) - 64'd1);
  endfunction

  function automatic logic [31:0] model_slot(input logic [4:0] sel);
    return 32'(64'hFFFF_FFFF - (64'd1 << sel));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; m2 = 1'b0; map_ctrl = 24'h0; map_ctrl_b = 24'h0;
    map_ctrl_req = 1'b0; req_b = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (3) tick();
    cur_sel = 5'd0; cur_args = 7'd0;
    checks++; if (select !== 5'd0 || map_args !== 7'd0) $display("FAIL reset_sel: got sel=%0d args=%0d want 0/0", select, map_args); else passed++;
    checks++; if (map_reset !== 32'hFFFF_FFFE) $display("FAIL reset_vec: got %h want fffffffe", map_reset); else passed++;
    checks++; if (prg_mask !== 23'd0 || chr_base !== 23'd1) $display("FAIL reset_mask: got mask=%h base=%h want 0/1", prg_mask, chr_base); else passed++;
    checks++; if (map_ctrl_ack !== 1'b0 || busy !== 1'b0 || err !== 1'b0) $display("FAIL reset_status: got ack=%b busy=%b err=%b want 000", map_ctrl_ack, busy, err); else passed++;
    checks++; if (map_reset_b !== 16'hFFFE || ack_b !== 1'b0) $display("FAIL reset_b: got vec=%h ack=%b want fffe/0", map_reset_b, ack_b); else passed++;
  endtask

  task automatic test_basic_switch();
    int n, busy_at, ones;
    logic want;
    m2 = 1'b0; repeat (4) tick();
    map_ctrl = 24'h0000A2;
    want = ~map_ctrl_req; map_ctrl_req = want;
    n = 0; busy_at = -1; ones = 0;
    while (map_ctrl_ack !== want && n < 200) begin
      tick(); n++;
      if (busy === 1'b1 && busy_at < 0) busy_at = n;
      if (map_reset === 32'hFFFF_FFFF) ones++;
    end
    cur_sel = 5'd2; cur_args = 7'd5;
    checks++; if (n !== REQ_LAT) $display("FAIL basic_latency: got %0d want %0d", n, REQ_LAT); else passed++;
    checks++; if (busy_at !== SYNC_LAT + 1) $display("FAIL basic_busy_rise: got %0d want %0d", busy_at, SYNC_LAT + 1); else passed++;
    checks++; if (ones !== HOLD_CYCLES) $display("FAIL basic_hold_len: got %0d want %0d", ones, HOLD_CYCLES); else passed++;
    checks++; if (select !== 5'd2 || map_args !== 7'd5) $display("FAIL basic_sel: got %0d/%0d want 2/5", select, map_args); else passed++;
    checks++; if (prg_mask !== 23'h1F || chr_base !== 23'h20) $display("FAIL basic_mask: got %h/%h want 1f/20", prg_mask, chr_base); else passed++;
    checks++; if (map_reset !== 32'hFFFF_FFFB || busy !== 1'b0 || err !== 1'b0) $display("FAIL basic_vec: got %h busy=%b err=%b want fffffffb/0/0", map_reset, busy, err); else passed++;
  endtask

  task automatic test_m2_activity();
    int n, bad;
    logic want;
    logic [6:0] a;
    a = 7'($urandom_range(0, 127));
    m2 = 1'b1; repeat (3) tick();
    map_ctrl = {12'($urandom_range(0, 4095)), a, 5'd3};
    want = ~map_ctrl_req; map_ctrl_req = want;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      m2 = ~m2;
      if (select !== cur_sel || map_reset !== model_slot(cur_sel) || map_ctrl_ack === want) bad++;
      if (i >= SYNC_LAT + 1 && busy !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL m2_stall: got %0d bad cycles want 0", bad); else passed++;
    m2 = 1'b1; repeat (3) tick();
    m2 = 1'b0;
    n = 0;
    while (map_ctrl_ack !== want && n < 200) begin tick(); n++; end
    cur_sel = 5'd3; cur_args = a;
    checks++; if (n !== SYNC_LAT + IDLE_CYCLES + HOLD_CYCLES + 2) $display("FAIL m2_latency: got %0d want %0d", n, SYNC_LAT + IDLE_CYCLES + HOLD_CYCLES + 2); else passed++;
    checks++; if (select !== 5'd3 || map_args !== a || prg_mask !== model_mask(a) || chr_base !== model_base(a)) $display("FAIL m2_result: got sel=%0d args=%h mask=%h base=%h want 3/%h/%h/%h", select, map_args, prg_mask, chr_base, a, model_mask(a), model_base(a)); else passed++;
  endtask

  task automatic test_random_switch();
    int n, ones;
    logic want;
    logic [4:0] s;
    logic [6:0] a;
    m2 = 1'b0; repeat (4) tick();
    for (int it = 0; it < 8; it++) begin
      s = 5'($urandom_range(0, 31));
      a = 7'($urandom_range(0, 127));
      if (it == 0) s = cur_sel;
      if (it == 1) a = {a[6:5], 5'd31};
      if (it == 2) a = {a[6:5], 5'd0};
      if (it == 3) a = {a[6:5], 5'd23};
      map_ctrl = {12'($urandom_range(0, 4095)), a, s};
      want = ~map_ctrl_req; map_ctrl_req = want;
      n = 0; ones = 0;
      while (map_ctrl_ack !== want && n < 200) begin
        tick(); n++;
        if (map_reset === 32'hFFFF_FFFF) ones++;
      end
      cur_sel = s; cur_args = a;
      checks++; if (n !== REQ_LAT || ones !== HOLD_CYCLES) $display("FAIL rand_timing[%0d]: got lat=%0d hold=%0d want %0d/%0d", it, n, ones, REQ_LAT, HOLD_CYCLES); else passed++;
      checks++; if (select !== s || map_args !== a || map_reset !== model_slot(s) || prg_mask !== model_mask(a) || chr_base !== model_base(a) || err !== 1'b0)
        $display("FAIL rand_result[%0d]: got sel=%0d args=%h vec=%h mask=%h base=%h err=%b want %0d/%h/%h/%h/%h/0", it, select, map_args, map_reset, prg_mask, chr_base, err, s, a, model_slot(s), model_mask(a), model_base(a));
      else passed++;
    end
  endtask

  task automatic test_invalid_select();
    int n;
    logic want;
    m2 = 1'b0; repeat (4) tick();
    map_ctrl_b = {12'h5A5, 7'h2A, 5'd31};
    want = ~req_b; req_b = want;
    n = 0;
    while (ack_b !== want && n < 50) begin tick(); n++; end
    checks++; if (n !== SYNC_LAT + 2) $display("FAIL inv_latency: got %0d want %0d", n, SYNC_LAT + 2); else passed++;
    checks++; if (err_b !== 1'b1 || select_b !== 5'd0 || args_b !== 7'd0 || map_reset_b !== 16'hFFFE || busy_b !== 1'b0)
      $display("FAIL inv_result: got err=%b sel=%0d args=%h vec=%h busy=%b want 1/0/0/fffe/0", err_b, select_b, args_b, map_reset_b, busy_b);
    else passed++;
    map_ctrl_b = {12'h000, 7'h03, 5'd9};
    want = ~req_b; req_b = want;
    n = 0;
    while (ack_b !== want && n < 200) begin tick(); n++; end
    checks++; if (n !== REQ_LAT || err_b !== 1'b0 || select_b !== 5'd9 || map_reset_b !== 16'hFDFF || prg_mask_b !== 23'h7 || chr_base_b !== 23'h8)
      $display("FAIL inv_recover: got lat=%0d err=%b sel=%0d vec=%h mask=%h base=%h want %0d/0/9/fdff/7/8", n, err_b, select_b, map_reset_b, prg_mask_b, chr_base_b, REQ_LAT);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int n, bad;
    logic want1, want2, want3;
    m2 = 1'b0; repeat (4) tick();
    // Two toggles during HOLD cancel: exactly one switch.
    map_ctrl = {12'h0, 7'd2, 5'd7};
    want1 = ~map_ctrl_req; map_ctrl_req = want1;
    n = 0;
    while (map_reset !== 32'hFFFF_FFFF && n < 50) begin tick(); n++; end
    map_ctrl_req = ~map_ctrl_req; repeat (3) tick();
    map_ctrl_req = ~map_ctrl_req;
    n = 0;
    while (map_ctrl_ack !== want1 && n < 100) begin tick(); n++; end
    cur_sel = 5'd7; cur_args = 7'd2;
    checks++; if (map_ctrl_ack !== want1 || select !== 5'd7) $display("FAIL b2b_cancel_first: got ack=%b sel=%0d want %b/7", map_ctrl_ack, select, want1); else passed++;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy !== 1'b0 || map_ctrl_ack !== want1 || map_reset !== model_slot(5'd7)) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL b2b_cancel_quiet: got %0d bad cycles want 0", bad); else passed++;
    // A single toggle during HOLD is served by a second full sequence.
    map_ctrl = {12'h0, 7'd4, 5'd11};
    want2 = ~map_ctrl_req; map_ctrl_req = want2;
    n = 0;
    while (map_reset !== 32'hFFFF_FFFF && n < 50) begin tick(); n++; end
    map_ctrl = {12'h0, 7'd6, 5'd12};
    want3 = ~want2; map_ctrl_req = want3;
    n = 0;
    while (map_ctrl_ack !== want2 && n < 100) begin tick(); n++; end
    checks++; if (map_ctrl_ack !== want2 || select !== 5'd11) $display("FAIL b2b_first: got ack=%b sel=%0d want %b/11", map_ctrl_ack, select, want2); else passed++;
    n = 0;
    while (map_ctrl_ack !== want3 && n < 100) begin tick(); n++; end
    cur_sel = 5'd12; cur_args = 7'd6;
    checks++; if (n !== SWITCH_LAT || select !== 5'd12 || map_reset !== model_slot(5'd12) || prg_mask !== model_mask(7'd6))
      $display("FAIL b2b_second: got lat=%0d sel=%0d vec=%h mask=%h want %0d/12/%h/%h", n, select, map_reset, prg_mask, SWITCH_LAT, model_slot(5'd12), model_mask(7'd6));
    else passed++;
  endtask

  task automatic test_reset_mid();
    int n;
    reset = 1'b1; map_ctrl_req = 1'b0; req_b = 1'b0; m2 = 1'b0;
    repeat (2) tick();
    reset = 1'b0; repeat (3) tick();
    map_ctrl = {12'h0, 7'd9, 5'd20};
    map_ctrl_req = 1'b1;
    n = 0;
    while (map_reset !== 32'hFFFF_FFFF && n < 50) begin tick(); n++; end
    reset = 1'b1;
    tick();
    checks++; if (select !== 5'd0 || map_reset !== 32'hFFFF_FFFE || prg_mask !== 23'd0 || chr_base !== 23'd1 || map_ctrl_ack !== 1'b0 || busy !== 1'b0 || err !== 1'b0)
      $display("FAIL midreset_values: got sel=%0d vec=%h mask=%h base=%h ack=%b busy=%b err=%b want 0/fffffffe/0/1/0/0/0", select, map_reset, prg_mask, chr_base, map_ctrl_ack, busy, err);
    else passed++;
    reset = 1'b0;
    n = 0;
    while (map_ctrl_ack !== 1'b1 && n < 200) begin tick(); n++; end
    cur_sel = 5'd20; cur_args = 7'd9;
    checks++; if (n !== REQ_LAT || select !== 5'd20 || map_reset !== model_slot(5'd20))
      $display("FAIL midreset_reserve: got lat=%0d sel=%0d vec=%h want %0d/20/%h", n, select, map_reset, REQ_LAT, model_slot(5'd20));
    else passed++;
  endtask

  task automatic test_stuck_m2();
    int n, err_at, hold_at;
    logic want;
    m2 = 1'b1; repeat (3) tick();
    map_ctrl = {12'h0, 7'd3, 5'd4};
    want = ~map_ctrl_req; map_ctrl_req = want;
`ifdef MAP_SWITCH_WDT_EN
    n = 0; err_at = -1; hold_at = -1;
    while (map_ctrl_ack !== want && n < 400) begin
      tick(); n++;
      if (err === 1'b1 && err_at < 0) err_at = n;
      if (map_reset === 32'hFFFF_FFFF && hold_at < 0) hold_at = n;
    end
    checks++; if (err_at !== SYNC_LAT + 1 + WDT_CYCLES || hold_at !== SYNC_LAT + 2 + WDT_CYCLES)
      $display("FAIL wdt_timeout: got err_at=%0d hold_at=%0d want %0d/%0d", err_at, hold_at, SYNC_LAT + 1 + WDT_CYCLES, SYNC_LAT + 2 + WDT_CYCLES);
    else passed++;
    checks++; if (n !== SYNC_LAT + 1 + WDT_CYCLES + HOLD_CYCLES + 2 || err !== 1'b0 || select !== 5'd4)
      $display("FAIL wdt_complete: got lat=%0d err=%b sel=%0d want %0d/0/4", n, err, select, SYNC_LAT + 1 + WDT_CYCLES + HOLD_CYCLES + 2);
    else passed++;
`else
    err_at = 0; hold_at = 0;
    for (int i = 0; i < 2 * WDT_CYCLES; i++) begin
      tick();
      if (err !== 1'b0) err_at++;
      if (i >= SYNC_LAT + 1 && (busy !== 1'b1 || select !== cur_sel || map_reset !== model_slot(cur_sel) || map_ctrl_ack === want)) hold_at++;
    end
    checks++; if (err_at !== 0 || hold_at !== 0) $display("FAIL stuck_wait: got err_cycles=%0d bad_cycles=%0d want 0/0", err_at, hold_at); else passed++;
    m2 = 1'b0;
    n = 0;
    while (map_ctrl_ack !== want && n < 200) begin tick(); n++; end
    checks++; if (n !== SYNC_LAT + IDLE_CYCLES + HOLD_CYCLES + 2 || select !== 5'd4 || err !== 1'b0)
      $display("FAIL stuck_release: got lat=%0d sel=%0d err=%b want %0d/4/0", n, select, err, SYNC_LAT + IDLE_CYCLES + HOLD_CYCLES + 2);
    else passed++;
`endif
    cur_sel = 5'd4; cur_args = 7'd3;
  endtask

  initial begin
    test_reset();
    test_basic_switch();
    test_m2_activity();
    test_random_switch();
    test_invalid_select();
    test_back_to_back();
    test_reset_mid();
    test_stuck_m2();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit, %0d/%0d checks passed", passed, checks);
    $fatal(1);
  end
endmodule
